pipe_stage_reg: RTL
===================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 96, payload width in bits (e.g. instruction + PC + PC+4).
REQ-002 Parameter BUBBLE, WIDTH bits, default all-zero, payload value presented when the stage holds no valid entry.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  stage enable; low = stall, all state held.
REQ-006 clr  input  1  synchronous flush, inserts bubble.
REQ-007 in_valid  input  1  upstream payload valid.
REQ-008 in_ready  output  1  stage can accept payload this cycle.
REQ-009 in_data  input  WIDTH  upstream payload.
REQ-010 out_valid  output  1  stage presents a valid payload.
REQ-011 out_ready  input  1  downstream accepts payload this cycle.
REQ-012 out_data  output  WIDTH  presented payload; equals BUBBLE when out_valid is low.
REQ-013 count  output  2  number of valid entries held (0..2).

Function
REQ-014 Input transfer SHALL occur iff in_valid && in_ready; output transfer iff out_valid && out_ready.
REQ-015 Entries SHALL leave in strict arrival order; no entry duplicated or dropped except by clr.
REQ-016 With en=0 and clr=0: in_ready=0, out_valid=0, out_data=BUBBLE, all internal state held.
REQ-017 With clr=1: in_ready=0 that cycle; next edge empties the stage (count=0, out_data=BUBBLE); clr overrides en.
REQ-018 in_valid arriving in a clr cycle SHALL be discarded; the upstream is not stalled.
REQ-019 Latency: payload accepted at edge N SHALL appear on out_data after edge N when the stage was empty.
REQ-020 Simultaneous input and output transfer SHALL leave count unchanged and forward the next entry in order.
REQ-021 out_data SHALL be driven from a register (no combinational path from in_data to out_data).
REQ-022 count SHALL be 0 exactly when out_valid is low with en=1.

Reset
REQ-023 rst=1 SHALL immediately force count=0, out_valid=0, out_data=BUBBLE, internal state EMPTY, independent of clk.
REQ-024 rst deassertion SHALL cause no transfer in the following cycle unless in_valid && in_ready hold then.
REQ-025 rst asserted mid-transfer SHALL discard all held entries.

Configuration
REQ-026 Macro PIPE_STAGE_REG_SKID_EN defined: 2-entry skid buffer; FSM states EMPTY, ONE, TWO; in_ready = en && !clr && (state != TWO), with the state term registered; full throughput with registered ready.
REQ-027 Skid transitions: EMPTY-in->ONE; ONE-in,no out->TWO; ONE-out,no in->EMPTY; TWO-out->ONE (in_ready low in TWO); ONE-in+out->ONE.
REQ-028 Macro undefined: single entry; states EMPTY, FULL; in_ready = en && !clr && (state==EMPTY || out_ready) (combinational through out_ready); count never exceeds 1.
REQ-029 Port list and parameters SHALL be identical in both builds.

Verification
REQ-030 Reset: rst=1 mid-stream with count=2 -> out_valid=0, count=0, out_data=0 before next clk edge.
REQ-031 Streaming: in_valid=1 with data 0x1..0x8, out_ready=1 -> out_data 0x1..0x8 on consecutive cycles, one-cycle latency, no gaps.
REQ-032 Backpressure (SKID_EN): out_ready=0 while sending 0xA,0xB,0xC -> count=2, in_ready=0 after 0xB, 0xC held upstream; out_ready=1 -> 0xA,0xB,0xC in order.
REQ-033 Stall: en=0 for 3 cycles holding 0x55 -> count unchanged, out_valid=0; en=1 -> 0x55 delivered once.
REQ-034 Flush: clr=1 with count=2 and in_valid=1 (data 0x77) -> next cycle count=0, out_data=BUBBLE, 0x77 never output.
REQ-035 Non-SKID build: out_ready=0 with count=1 -> in_ready=0 same cycle; out_ready=1 with in_valid=1 -> simultaneous transfer, count stays 1.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, stall (en) and flush (clr).
// Define PIPE_STAGE_REG_SKID_EN for a 2-entry skid buffer with registered in_ready.
module pipe_stage_reg #(
  parameter int               WIDTH  = 96,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [WIDTH-1:0] r_head;

`ifdef PIPE_STAGE_REG_SKID_EN
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_tail;

  // Ready depends only on registered state, breaking the out_ready -> in_ready path.
  assign in_ready  = en && !clr && (r_state != S_TWO);
  assign out_valid = en && (r_state != S_EMPTY);
  assign count     = r_state;

  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_head  <= BUBBLE;
      r_tail  <= BUBBLE;
    end else if (clr) begin
      r_state <= S_EMPTY;
      r_head  <= BUBBLE;
      r_tail  <= BUBBLE;
    end else if (en) begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_xfer) begin
            r_head  <= in_data;
            r_state <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            r_head <= in_data;
          end else if (w_in_xfer) begin
            r_tail  <= in_data;
            r_state <= S_TWO;
          end else if (w_out_xfer) begin
            r_state <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_out_xfer) begin
            r_head  <= r_tail;
            r_state <= S_ONE;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end
`else
  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t r_state;

  // Single entry: refill in the same cycle it drains, so ready looks through out_ready.
  assign in_ready  = en && !clr && ((r_state == S_EMPTY) || out_ready);
  assign out_valid = en && (r_state == S_FULL);
  assign count     = {1'b0, r_state == S_FULL};

  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_head  <= BUBBLE;
    end else if (clr) begin
      r_state <= S_EMPTY;
      r_head  <= BUBBLE;
    end else if (en) begin
      if (w_in_xfer) begin
        r_head  <= in_data;
        r_state <= S_FULL;
      end else if (w_out_xfer) begin
        r_state <= S_EMPTY;
      end
    end
  end
`endif

  assign out_data = out_valid ? r_head : BUBBLE;

endmodule
